// File: rtl/operand_mux_pkg.sv
// Shared types and helpers for the ALU operand select multiplexer.
package operand_mux_pkg;

    // Top-level sequencer states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // Select width for a given channel count; never narrower than one bit
    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/operand_select_mux_word_mux_n.sv
// Purely combinational CHANNELS:1 multiplexer of WIDTH-bit words.
// Returns zero and deasserts o_hit_c when the select names no channel.
module word_mux_n
    import operand_mux_pkg::*;
#(
    parameter  int unsigned WIDTH    = 4,
    parameter  int unsigned CHANNELS = 16,
    localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]          i_sel,
    output logic [WIDTH-1:0]          o_data_c,
    output logic                      o_hit_c
);

    // One-hot compare per channel; out-of-range selects match nothing
    always_comb begin
        o_data_c = '0;
        o_hit_c  = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (i_sel == SEL_W'(c)) begin
                o_data_c = i_data[c*WIDTH +: WIDTH];
                o_hit_c  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_select_mux.sv
// Registered N:1 operand multiplexer with valid/ready output stage, an
// automatic scan sequencer covering every channel in order, and a sticky
// illegal-select flag.
// Optional feature macro: OPERAND_SELECT_PARITY_EN adds out_par, the XOR
// reduction of out_data, registered alongside it.
module operand_select_mux
    import operand_mux_pkg::*;
#(
    parameter  int unsigned WIDTH    = 4,
    parameter  int unsigned CHANNELS = 16,
    localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      start,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      err_sel
`ifdef OPERAND_SELECT_PARITY_EN
    ,
    output logic                      out_par
`endif
);

    localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(CHANNELS - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [SEL_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_chan;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_err_sel;

    logic             w_load;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_scan_beat;
    logic             w_beat;
    logic             w_cnt_last;
    logic             w_hit;
    logic [SEL_W-1:0] w_mux_sel;
    logic [WIDTH-1:0] w_mux_data;

    // Output register may take a new beat when empty or being drained
    assign w_load     = ~r_out_valid | out_ready;
    assign w_cnt_last = (r_cnt == LAST_CHAN);

    word_mux_n #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_word_mux (
        .i_data   (in_data),
        .i_sel    (w_mux_sel),
        .o_data_c (w_mux_data),
        .o_hit_c  (w_hit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: start opens a scan, final channel load closes it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (w_scan_beat && w_cnt_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode: handshake readiness, scan beat strobe and mux select
    always_comb begin
        w_in_ready  = 1'b0;
        w_scan_beat = 1'b0;
        w_mux_sel   = sel;
        case (r_state)
            IDLE: begin
                w_in_ready = w_load & ~start;
            end
            SCAN: begin
                w_scan_beat = w_load;
                w_mux_sel   = r_cnt;
            end
            default: begin
                w_in_ready  = 1'b0;
                w_scan_beat = 1'b0;
            end
        endcase
    end

    assign w_accept = in_valid & w_in_ready;
    assign w_beat   = w_accept | w_scan_beat;

    // Scan channel counter; holds while the output stage is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_cnt <= '0;
        end else if (w_scan_beat) begin
            r_cnt <= w_cnt_last ? '0 : r_cnt + SEL_W'(1);
        end
    end

    // One-entry output pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_beat) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
            r_out_chan  <= w_mux_sel;
            r_out_last  <= w_scan_beat & w_cnt_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky flag for an accepted direct request naming no channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sel <= 1'b0;
        end else if (w_accept && !w_hit) begin
            r_err_sel <= 1'b1;
        end
    end

`ifdef OPERAND_SELECT_PARITY_EN
    logic r_out_par;

    // Parity of the word captured into the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_par <= 1'b0;
        end else if (w_beat) begin
            r_out_par <= ^w_mux_data;
        end
    end

    assign out_par = r_out_par;
`endif

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = (r_state == SCAN);
    assign err_sel   = r_err_sel;

endmodule

// File: tb/tb_operand_select_mux.sv
// Directed bench: 16-channel instance checked through an expected-beat queue,
// 12-channel instance used for illegal-select behaviour.
module tb_operand_select_mux;

    typedef struct packed {
        logic [3:0] data;
        logic [3:0] chan;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [63:0] a_in_data;
    logic [3:0]  a_sel;
    logic        a_in_valid, a_in_ready, a_start;
    logic [3:0]  a_out_data, a_out_chan;
    logic        a_out_valid, a_out_ready, a_out_last, a_busy, a_err_sel;

    logic [47:0] b_in_data;
    logic [3:0]  b_sel;
    logic        b_in_valid, b_in_ready, b_start;
    logic [3:0]  b_out_data, b_out_chan;
    logic        b_out_valid, b_out_ready, b_out_last, b_busy, b_err_sel;

`ifdef OPERAND_SELECT_PARITY_EN
    logic        a_out_par, b_out_par;
`endif

    beat_t exp_q[$];
    int    n_pass   = 0;
    int    n_fail   = 0;
    int    n_checks = 0;
    int    n_beats  = 0;

    always #5 clk = ~clk;

    operand_select_mux #(.WIDTH(4), .CHANNELS(16)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (a_in_data),
        .sel       (a_sel),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .start     (a_start),
        .out_data  (a_out_data),
        .out_chan  (a_out_chan),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_last  (a_out_last),
        .busy      (a_busy),
        .err_sel   (a_err_sel)
`ifdef OPERAND_SELECT_PARITY_EN
        ,
        .out_par   (a_out_par)
`endif
    );

    operand_select_mux #(.WIDTH(4), .CHANNELS(12)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in_data),
        .sel       (b_sel),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .start     (b_start),
        .out_data  (b_out_data),
        .out_chan  (b_out_chan),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_last  (b_out_last),
        .busy      (b_busy),
        .err_sel   (b_err_sel)
`ifdef OPERAND_SELECT_PARITY_EN
        ,
        .out_par   (b_out_par)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_beat(input logic [3:0] d, input logic [3:0] c, input logic l);
        beat_t b;
        b.data = d;
        b.chan = c;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic push_scan(input logic [63:0] d);
        for (int c = 0; c < 16; c++) begin
            push_beat(d[c*4 +: 4], 4'(c), (c == 15));
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic b_req(input logic [3:0] s, input logic [3:0] ed, input logic ee);
        @(posedge clk); #1;
        b_sel      = s;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_valid", 32'(b_out_valid), 32'd1);
        chk("b_data",  32'(b_out_data),  32'(ed));
        chk("b_chan",  32'(b_out_chan),  32'(s));
        chk("b_last",  32'(b_out_last),  32'd0);
        chk("b_err",   32'(b_err_sel),   32'(ee));
    endtask

    // Scoreboard: compare every beat consumed by the downstream handshake
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", 32'(a_out_data), 32'(e.data));
                chk("beat_chan", 32'(a_out_chan), 32'(e.chan));
                chk("beat_last", 32'(a_out_last), 32'(e.last));
`ifdef OPERAND_SELECT_PARITY_EN
                chk("beat_par", 32'(a_out_par), 32'(^e.data));
`endif
                n_beats++;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        a_in_data   = '0;
        a_sel       = '0;
        a_in_valid  = 1'b0;
        a_start     = 1'b0;
        a_out_ready = 1'b0;
        b_in_data   = '0;
        b_sel       = '0;
        b_in_valid  = 1'b0;
        b_start     = 1'b0;
        b_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid",    32'(a_out_valid), 32'd0);
        chk("rst_data",     32'(a_out_data),  32'd0);
        chk("rst_chan",     32'(a_out_chan),  32'd0);
        chk("rst_last",     32'(a_out_last),  32'd0);
        chk("rst_busy",     32'(a_busy),      32'd0);
        chk("rst_err",      32'(a_err_sel),   32'd0);
        chk("rst_in_ready", 32'(a_in_ready),  32'd1);
        chk("rst_b_err",    32'(b_err_sel),   32'd0);

        // Direct requests: sel 9, then back-to-back 0 and 15
        @(posedge clk); #1;
        for (int c = 0; c < 16; c++) a_in_data[c*4 +: 4] = 4'(c * 7 + 3);
        a_in_data[9*4 +: 4] = 4'hA;
        a_out_ready = 1'b1;
        a_sel       = 4'd9;
        a_in_valid  = 1'b1;
        push_beat(4'hA, 4'd9, 1'b0);
        @(negedge clk);
        chk("direct_in_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
        a_sel = 4'd0;
        push_beat(a_in_data[3:0], 4'd0, 1'b0);
        @(negedge clk);
        chk("direct_latency_valid", 32'(a_out_valid), 32'd1);
        chk("direct_latency_chan",  32'(a_out_chan),  32'd9);
        @(posedge clk); #1;
        a_sel = 4'd15;
        push_beat(a_in_data[63:60], 4'd15, 1'b0);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        drain("drain_direct");

        // Full scan, start re-pulsed mid-scan, direct request waiting behind it
        @(posedge clk); #1;
        for (int c = 0; c < 16; c++) a_in_data[c*4 +: 4] = 4'(c);
        a_start = 1'b1;
        push_scan(a_in_data);
        @(posedge clk); #1;
        a_start    = 1'b0;
        a_in_valid = 1'b1;
        a_sel      = 4'd2;
        push_beat(4'd2, 4'd2, 1'b0);
        n = 0;
        while (!a_in_ready && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("scan_busy",     32'(a_busy),     32'd1);
                chk("scan_in_ready", 32'(a_in_ready), 32'd0);
            end
            if (n == 3) a_start = 1'b1;
            if (n == 4) a_start = 1'b0;
        end
        chk("req_after_scan_cycle", 32'(n),      32'd17);
        chk("busy_after_scan",      32'(a_busy), 32'd0);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        drain("drain_scan1");

        // Start and in_valid together, then stall three cycles on channel 5
        @(posedge clk); #1;
        for (int c = 0; c < 16; c++) a_in_data[c*4 +: 4] = 4'(15 - c);
        a_start    = 1'b1;
        a_in_valid = 1'b1;
        a_sel      = 4'd3;
        push_scan(a_in_data);
        @(negedge clk);
        chk("start_priority_in_ready", 32'(a_in_ready), 32'd0);
        @(posedge clk); #1;
        a_start    = 1'b0;
        a_in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(a_out_valid), 32'd1);
            chk("stall_chan",  32'(a_out_chan),  32'd5);
            chk("stall_data",  32'(a_out_data),  32'd10);
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        drain("drain_scan2");

        // Asynchronous reset mid-scan with a beat stalled
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        a_start     = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_valid", 32'(a_out_valid), 32'd1);
        chk("pre_reset_busy",  32'(a_busy),      32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    32'(a_out_valid), 32'd0);
        chk("mid_rst_data",     32'(a_out_data),  32'd0);
        chk("mid_rst_chan",     32'(a_out_chan),  32'd0);
        chk("mid_rst_last",     32'(a_out_last),  32'd0);
        chk("mid_rst_busy",     32'(a_busy),      32'd0);
        chk("mid_rst_in_ready", 32'(a_in_ready),  32'd1);
        @(posedge clk); #1;
        rst_n       = 1'b1;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_busy",  32'(a_busy),      32'd0);
        chk("post_rst_valid", 32'(a_out_valid), 32'd0);
        @(posedge clk); #1;
        a_sel      = 4'd7;
        a_in_valid = 1'b1;
        push_beat(a_in_data[31:28], 4'd7, 1'b0);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        drain("drain_post_rst");

        // Twelve-channel instance: range edge and sticky error
        for (int c = 0; c < 12; c++) b_in_data[c*4 +: 4] = 4'(c + 1);
        b_req(4'd11, 4'hC, 1'b0);
        b_req(4'd13, 4'h0, 1'b1);
        b_req(4'd4,  4'h5, 1'b1);
        b_req(4'd12, 4'h0, 1'b1);

        repeat (3) @(negedge clk);
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        chk("beat_count",  32'(n_beats),      32'd37);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
